// File: rtl/mips_multicycle_ctrl_if.sv
// Bus between the multi-cycle controller and the MIPS datapath / memory port.
// The controller takes the master modport; the datapath side takes the slave modport.
interface mips_multicycle_ctrl_if #(
    parameter int unsigned ALU_OP_W = 3,
    parameter int unsigned CNT_W    = 32
);
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                zero;
    logic                mem_ready;
    logic [2:0]          state;
    logic                ir_we;
    logic                pc_we;
    logic [1:0]          control_type;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src2;
    logic                rd_src;
    logic                reg_we;
    logic                mem_read;
    logic                word_we;
    logic                byte_we;
    logic                byte_load;
    logic                lui;
    logic                slt;
    logic                except;
    logic [1:0]          exc_cause;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output state, ir_we, pc_we, control_type, alu_op, alu_src2, rd_src, reg_we,
               mem_read, word_we, byte_we, byte_load, lui, slt, except, exc_cause, retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  state, ir_we, pc_we, control_type, alu_op, alu_src2, rd_src, reg_we,
               mem_read, word_we, byte_we, byte_load, lui, slt, except, exc_cause, retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with memory-ready handshake,
// illegal-opcode and bus-timeout traps, and a retired-instruction counter.
module mips_multicycle_ctrl #(
    parameter int unsigned ALU_OP_W = 3,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned TO_W     = 5,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_EXCEPT = 3'd5
    } state_e;

    localparam logic [5:0] OP_OTHER0 = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04, OP_BNE = 6'h05,
                           OP_ADDI   = 6'h08, OP_ANDI = 6'h0c, OP_ORI  = 6'h0d, OP_XORI = 6'h0e,
                           OP_LUI    = 6'h0f, OP_LW   = 6'h23, OP_LBU  = 6'h24, OP_SB  = 6'h28,
                           OP_SW     = 6'h2b;
    localparam logic [5:0] FN_JR  = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR  = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2a;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2), ALU_SUB = ALU_OP_W'(3),
                                    ALU_AND = ALU_OP_W'(4), ALU_OR  = ALU_OP_W'(5),
                                    ALU_NOR = ALU_OP_W'(6), ALU_XOR = ALU_OP_W'(7);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [5:0]       op_q, op_d;
    logic [5:0]       fn_q, fn_d;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_OTHER0: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_JR: is_legal = 1'b1;
                    default:                       is_legal = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
            OP_LUI, OP_LW, OP_LBU, OP_SB, OP_SW: is_legal = 1'b1;
            default:                             is_legal = 1'b0;
        endcase
    endfunction

    // Datapath controls decoded from the fields latched in DECODE.
    logic                is_beq, is_bne, is_j, is_jr, is_load, is_store, is_byte;
    logic [ALU_OP_W-1:0] dec_alu_op;
    logic                dec_src2, dec_rd_src, dec_lui, dec_slt;

    always_comb begin
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_jr      = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_byte    = 1'b0;
        dec_alu_op = ALU_ADD;
        dec_src2   = 1'b0;
        dec_rd_src = 1'b0;
        dec_lui    = 1'b0;
        dec_slt    = 1'b0;
        case (op_q)
            OP_OTHER0: begin
                case (fn_q)
                    FN_SUB:  dec_alu_op = ALU_SUB;
                    FN_AND:  dec_alu_op = ALU_AND;
                    FN_OR:   dec_alu_op = ALU_OR;
                    FN_XOR:  dec_alu_op = ALU_XOR;
                    FN_NOR:  dec_alu_op = ALU_NOR;
                    FN_SLT: begin
                        dec_alu_op = ALU_SUB;
                        dec_slt    = 1'b1;
                    end
                    FN_JR:   is_jr = 1'b1;
                    default: dec_alu_op = ALU_ADD;
                endcase
            end
            OP_J:   is_j = 1'b1;
            OP_BEQ: begin
                is_beq     = 1'b1;
                dec_alu_op = ALU_SUB;
            end
            OP_BNE: begin
                is_bne     = 1'b1;
                dec_alu_op = ALU_SUB;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec_src2   = 1'b1;
                dec_rd_src = 1'b1;
                dec_lui    = (op_q == OP_LUI);
                case (op_q)
                    OP_ANDI: dec_alu_op = ALU_AND;
                    OP_ORI:  dec_alu_op = ALU_OR;
                    OP_XORI: dec_alu_op = ALU_XOR;
                    default: dec_alu_op = ALU_ADD;
                endcase
            end
            OP_LW, OP_LBU: begin
                is_load    = 1'b1;
                is_byte    = (op_q == OP_LBU);
                dec_src2   = 1'b1;
                dec_rd_src = 1'b1;
            end
            OP_SB, OP_SW: begin
                is_store = 1'b1;
                is_byte  = (op_q == OP_SB);
                dec_src2 = 1'b1;
            end
            default: dec_alu_op = ALU_ADD;
        endcase
    end

    logic is_flow;
    logic retire;

    assign is_flow = is_beq | is_bne | is_j | is_jr;
    assign retire  = ((state_q == S_EXEC) && is_flow) ||
                     ((state_q == S_MEM) && is_store && bus.mem_ready) ||
                     (state_q == S_WB);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        retired_d = retired_q;
        op_d      = op_q;
        fn_d      = fn_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_EXCEPT;
                    cause_d = 2'd2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                op_d = bus.opcode;
                fn_d = bus.funct;
                if (is_legal(bus.opcode, bus.funct)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_EXCEPT;
                    cause_d = 2'd1;
                end
            end
            S_EXEC: begin
                if (is_flow)                  state_d = S_FETCH;
                else if (is_load || is_store) state_d = S_MEM;
                else                          state_d = S_WB;
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    state_d = is_store ? S_FETCH : S_WB;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_EXCEPT;
                    cause_d = 2'd3;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase
        if (state_d != state_q) cnt_d = '0;
        if (retire)             retired_d = retired_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            cause_q   <= '0;
            retired_q <= '0;
            op_q      <= '0;
            fn_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
            op_q      <= op_d;
            fn_q      <= fn_d;
        end
    end

    logic                ir_we_c, pc_we_c, reg_we_c, mem_read_c, word_we_c, byte_we_c;
    logic                alu_src2_c, rd_src_c, byte_load_c, lui_c, slt_c;
    logic [1:0]          ctl_type_c;
    logic [ALU_OP_W-1:0] alu_op_c;

    always_comb begin
        ir_we_c     = 1'b0;
        pc_we_c     = retire;
        reg_we_c    = 1'b0;
        mem_read_c  = 1'b0;
        word_we_c   = 1'b0;
        byte_we_c   = 1'b0;
        alu_op_c    = ALU_ADD;
        alu_src2_c  = 1'b0;
        rd_src_c    = 1'b0;
        byte_load_c = 1'b0;
        lui_c       = 1'b0;
        slt_c       = 1'b0;
        ctl_type_c  = 2'd0;
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_op_c    = dec_alu_op;
            alu_src2_c  = dec_src2;
            rd_src_c    = dec_rd_src;
            byte_load_c = is_load & is_byte;
            lui_c       = dec_lui;
            slt_c       = dec_slt;
        end
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                ir_we_c    = bus.mem_ready;
            end
            S_EXEC: begin
                // Branch select is the only output that looks at the live zero flag.
                if (is_beq)     ctl_type_c = bus.zero ? 2'd1 : 2'd0;
                else if (is_bne) ctl_type_c = bus.zero ? 2'd0 : 2'd1;
                else if (is_j)   ctl_type_c = 2'd2;
                else if (is_jr)  ctl_type_c = 2'd3;
            end
            S_MEM: begin
                mem_read_c = is_load;
                word_we_c  = is_store & ~is_byte;
                byte_we_c  = is_store & is_byte;
            end
            S_WB:    reg_we_c = 1'b1;
            default: ;
        endcase
    end

    // Strobes are gated by reset_n so they fall with reset, not at the next edge.
    assign bus.state        = state_q;
    assign bus.ir_we        = reset_n & ir_we_c;
    assign bus.pc_we        = reset_n & pc_we_c;
    assign bus.reg_we       = reset_n & reg_we_c;
    assign bus.mem_read     = reset_n & mem_read_c;
    assign bus.word_we      = reset_n & word_we_c;
    assign bus.byte_we      = reset_n & byte_we_c;
    assign bus.except       = reset_n & (state_q == S_EXCEPT);
    assign bus.control_type = ctl_type_c;
    assign bus.alu_op       = alu_op_c;
    assign bus.alu_src2     = alu_src2_c;
    assign bus.rd_src       = rd_src_c;
    assign bus.byte_load    = byte_load_c;
    assign bus.lui          = lui_c;
    assign bus.slt          = slt_c;
    assign bus.exc_cause    = cause_q;
    assign bus.retired      = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: hand-computed state sequences, strobes,
// traps and retire counts.
module tb_mips_multicycle_ctrl;

    logic clock;
    logic reset_n;
    int   errors;
    int   checks;

    mips_multicycle_ctrl_if #(.ALU_OP_W(3), .CNT_W(32)) bus ();

    mips_multicycle_ctrl #(
        .ALU_OP_W(3),
        .TIMEOUT (16),
        .TO_W    (5),
        .CNT_W   (32)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        tick(); tick();
        if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
        checks++;
        if (bus.mem_read !== 1'b0 || bus.ir_we !== 1'b0) begin
            errors++; $display("FAIL rst_strobes got=%b%b exp=00", bus.mem_read, bus.ir_we);
        end
        checks++;
        if (bus.retired !== 32'd0 || bus.exc_cause !== 2'd0 || bus.control_type !== 2'd0) begin
            errors++; $display("FAIL rst_regs got=%0d/%0d/%0d exp=0/0/0", bus.retired, bus.exc_cause, bus.control_type);
        end
        checks++;
        reset_n = 1'b1;
        #1;
        if (bus.state !== 3'd0 || bus.mem_read !== 1'b1) begin
            errors++; $display("FAIL rst_release got=%0d/%b exp=0/1", bus.state, bus.mem_read);
        end
        checks++;
    endtask

    task automatic test_addi();
        bus.opcode = 6'h08; bus.funct = 6'h00; bus.mem_ready = 1'b1;
        #1;
        if (bus.state !== 3'd0 || bus.ir_we !== 1'b1) begin
            errors++; $display("FAIL addi_fetch got=%0d/%b exp=0/1", bus.state, bus.ir_we);
        end
        checks++;
        tick();
        if (bus.state !== 3'd1) begin errors++; $display("FAIL addi_decode got=%0d exp=1", bus.state); end
        checks++;
        tick();
        if (bus.state !== 3'd2 || bus.reg_we !== 1'b0) begin
            errors++; $display("FAIL addi_exec got=%0d/%b exp=2/0", bus.state, bus.reg_we);
        end
        checks++;
        tick();
        if (bus.state !== 3'd4 || bus.reg_we !== 1'b1 || bus.alu_src2 !== 1'b1 ||
            bus.rd_src !== 1'b1 || bus.alu_op !== 3'd2 || bus.pc_we !== 1'b1) begin
            errors++;
            $display("FAIL addi_wb got=st%0d we%b src2%b rd%b op%0d pc%b exp=st4 we1 src2 1 rd1 op2 pc1",
                     bus.state, bus.reg_we, bus.alu_src2, bus.rd_src, bus.alu_op, bus.pc_we);
        end
        checks++;
        if (bus.retired !== 32'd0) begin errors++; $display("FAIL addi_ret_before got=%0d exp=0", bus.retired); end
        checks++;
        tick();
        if (bus.state !== 3'd0 || bus.retired !== 32'd1) begin
            errors++; $display("FAIL addi_ret_after got=%0d/%0d exp=0/1", bus.state, bus.retired);
        end
        checks++;
    endtask

    task automatic test_branch();
        logic       zv [2];
        logic [1:0] ct [2];
        zv[0] = 1'b1; ct[0] = 2'd1;
        zv[1] = 1'b0; ct[1] = 2'd0;
        for (int k = 0; k < 2; k++) begin
            bus.opcode = 6'h04; bus.funct = 6'h00; bus.zero = zv[k]; bus.mem_ready = 1'b1;
            #1;
            if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL beq%0d_f_regwe got=%b exp=0", k, bus.reg_we); end
            checks++;
            tick();
            if (bus.reg_we !== 1'b0 || bus.pc_we !== 1'b0) begin
                errors++; $display("FAIL beq%0d_d got=%b%b exp=00", k, bus.reg_we, bus.pc_we);
            end
            checks++;
            tick();
            if (bus.state !== 3'd2 || bus.control_type !== ct[k] || bus.pc_we !== 1'b1 || bus.reg_we !== 1'b0) begin
                errors++; $display("FAIL beq%0d_exec got=st%0d ct%0d pc%b we%b exp=st2 ct%0d pc1 we0",
                                   k, bus.state, bus.control_type, bus.pc_we, bus.reg_we, ct[k]);
            end
            checks++;
            tick();
            if (bus.state !== 3'd0 || bus.retired !== 32'(2 + k)) begin
                errors++; $display("FAIL beq%0d_ret got=%0d/%0d exp=0/%0d", k, bus.state, bus.retired, 2 + k);
            end
            checks++;
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        ops[0] = 6'h02; fns[0] = 6'h00;
        ops[1] = 6'h00; fns[1] = 6'h08;
        for (int k = 0; k < 2; k++) begin
            bus.opcode = ops[k]; bus.funct = fns[k]; bus.mem_ready = 1'b1;
            tick(); tick();
            if (bus.state !== 3'd2 || bus.control_type !== 2'(2 + k) || bus.pc_we !== 1'b1) begin
                errors++; $display("FAIL jump%0d_exec got=st%0d ct%0d pc%b exp=st2 ct%0d pc1",
                                   k, bus.state, bus.control_type, bus.pc_we, 2 + k);
            end
            checks++;
            tick();
        end
        if (bus.retired !== 32'd5) begin errors++; $display("FAIL jump_ret got=%0d exp=5", bus.retired); end
        checks++;
    endtask

    task automatic test_load();
        logic [2:0] exp_st [8];
        logic       rdy    [8];
        exp_st[0] = 3'd0; exp_st[1] = 3'd1; exp_st[2] = 3'd2; exp_st[3] = 3'd3;
        exp_st[4] = 3'd3; exp_st[5] = 3'd3; exp_st[6] = 3'd3; exp_st[7] = 3'd4;
        rdy[0] = 1'b1; rdy[1] = 1'b1; rdy[2] = 1'b1; rdy[3] = 1'b0;
        rdy[4] = 1'b0; rdy[5] = 1'b0; rdy[6] = 1'b1; rdy[7] = 1'b1;
        bus.opcode = 6'h23; bus.funct = 6'h00;
        for (int c = 0; c < 8; c++) begin
            bus.mem_ready = rdy[c];
            #1;
            if (bus.state !== exp_st[c]) begin
                errors++; $display("FAIL lw_c%0d_state got=%0d exp=%0d", c, bus.state, exp_st[c]);
            end
            checks++;
            if (bus.reg_we !== (exp_st[c] == 3'd4) || bus.pc_we !== (c == 7)) begin
                errors++; $display("FAIL lw_c%0d_we got=reg%b pc%b exp=reg%b pc%b",
                                   c, bus.reg_we, bus.pc_we, exp_st[c] == 3'd4, c == 7);
            end
            checks++;
            if (exp_st[c] == 3'd3) begin
                if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL lw_c%0d_mem_read got=%b exp=1", c, bus.mem_read); end
                checks++;
            end
            tick();
        end
        if (bus.state !== 3'd0 || bus.retired !== 32'd6) begin
            errors++; $display("FAIL lw_ret got=%0d/%0d exp=0/6", bus.state, bus.retired);
        end
        checks++;
    endtask

    task automatic test_store_timeout();
        bus.opcode = 6'h2b; bus.funct = 6'h00; bus.mem_ready = 1'b1;
        tick(); tick();
        bus.mem_ready = 1'b0;
        tick();
        for (int c = 0; c < 16; c++) begin
            if (bus.state !== 3'd3 || bus.word_we !== 1'b1 || bus.except !== 1'b0) begin
                errors++; $display("FAIL sw_mem%0d got=st%0d we%b ex%b exp=st3 we1 ex0",
                                   c, bus.state, bus.word_we, bus.except);
            end
            checks++;
            tick();
        end
        if (bus.state !== 3'd5 || bus.except !== 1'b1 || bus.exc_cause !== 2'd3) begin
            errors++; $display("FAIL sw_except got=st%0d ex%b cause%0d exp=st5 ex1 cause3",
                               bus.state, bus.except, bus.exc_cause);
        end
        checks++;
        if (bus.word_we !== 1'b0 || bus.pc_we !== 1'b0 || bus.retired !== 32'd6) begin
            errors++; $display("FAIL sw_except_side got=we%b pc%b ret%0d exp=we0 pc0 ret6",
                               bus.word_we, bus.pc_we, bus.retired);
        end
        checks++;
        tick();
        if (bus.state !== 3'd0 || bus.except !== 1'b0 || bus.exc_cause !== 2'd3) begin
            errors++; $display("FAIL sw_after got=st%0d ex%b cause%0d exp=st0 ex0 cause3",
                               bus.state, bus.except, bus.exc_cause);
        end
        checks++;
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        ops[0] = 6'h3f; fns[0] = 6'h00;
        ops[1] = 6'h00; fns[1] = 6'h01;
        for (int k = 0; k < 2; k++) begin
            bus.opcode = ops[k]; bus.funct = fns[k]; bus.mem_ready = 1'b1;
            tick();
            if (bus.state !== 3'd1 || bus.pc_we !== 1'b0) begin
                errors++; $display("FAIL ill%0d_decode got=st%0d pc%b exp=st1 pc0", k, bus.state, bus.pc_we);
            end
            checks++;
            tick();
            if (bus.state !== 3'd5 || bus.except !== 1'b1 || bus.exc_cause !== 2'd1 || bus.pc_we !== 1'b0) begin
                errors++; $display("FAIL ill%0d_except got=st%0d ex%b cause%0d pc%b exp=st5 ex1 cause1 pc0",
                                   k, bus.state, bus.except, bus.exc_cause, bus.pc_we);
            end
            checks++;
            tick();
        end
        if (bus.retired !== 32'd6) begin errors++; $display("FAIL ill_ret got=%0d exp=6", bus.retired); end
        checks++;
    endtask

    task automatic test_fetch_timeout();
        bus.mem_ready = 1'b0;
        #1;
        for (int c = 0; c < 16; c++) begin
            if (bus.state !== 3'd0 || bus.mem_read !== 1'b1) begin
                errors++; $display("FAIL ftmo_c%0d got=st%0d rd%b exp=st0 rd1", c, bus.state, bus.mem_read);
            end
            checks++;
            tick();
        end
        if (bus.state !== 3'd5 || bus.exc_cause !== 2'd2) begin
            errors++; $display("FAIL ftmo_except got=st%0d cause%0d exp=st5 cause2", bus.state, bus.exc_cause);
        end
        checks++;
        tick();
        // Ready on the 16th waiting cycle must complete the fetch, not trap.
        bus.opcode = 6'h08; bus.funct = 6'h00;
        for (int c = 0; c < 15; c++) tick();
        bus.mem_ready = 1'b1;
        #1;
        if (bus.state !== 3'd0 || bus.ir_we !== 1'b1) begin
            errors++; $display("FAIL flimit_fetch got=st%0d ir%b exp=st0 ir1", bus.state, bus.ir_we);
        end
        checks++;
        tick();
        if (bus.state !== 3'd1 || bus.except !== 1'b0) begin
            errors++; $display("FAIL flimit_decode got=st%0d ex%b exp=st1 ex0", bus.state, bus.except);
        end
        checks++;
        tick(); tick();
        if (bus.state !== 3'd4 || bus.pc_we !== 1'b1) begin
            errors++; $display("FAIL flimit_wb got=st%0d pc%b exp=st4 pc1", bus.state, bus.pc_we);
        end
        checks++;
        tick();
        if (bus.retired !== 32'd7) begin errors++; $display("FAIL flimit_ret got=%0d exp=7", bus.retired); end
        checks++;
    endtask

    task automatic test_reset_mid_store();
        bus.opcode = 6'h28; bus.funct = 6'h00; bus.mem_ready = 1'b1;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0;
        #1;
        if (bus.state !== 3'd3 || bus.byte_we !== 1'b1 || bus.word_we !== 1'b0) begin
            errors++; $display("FAIL sb_mem got=st%0d bwe%b wwe%b exp=st3 bwe1 wwe0",
                               bus.state, bus.byte_we, bus.word_we);
        end
        checks++;
        #1 reset_n = 1'b0;
        #1;
        if (bus.byte_we !== 1'b0 || bus.state !== 3'd0 || bus.mem_read !== 1'b0) begin
            errors++; $display("FAIL sb_reset got=bwe%b st%0d rd%b exp=bwe0 st0 rd0",
                               bus.byte_we, bus.state, bus.mem_read);
        end
        checks++;
        tick();
        reset_n = 1'b1;
        #1;
        if (bus.state !== 3'd0 || bus.retired !== 32'd0 || bus.exc_cause !== 2'd0) begin
            errors++; $display("FAIL sb_release got=st%0d ret%0d cause%0d exp=st0 ret0 cause0",
                               bus.state, bus.retired, bus.exc_cause);
        end
        checks++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_addi();
        test_branch();
        test_jump();
        test_load();
        test_store_timeout();
        test_illegal();
        test_fetch_timeout();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
